// File: rtl/if_fetch_stage.sv
// Instruction fetch stage and IF/ID pipeline register.
// Owns the PC, the imem handshake, stall/redirect handling.
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic             PCWrite,
    input  logic             IF_ID_Write,
    input  logic             Branch_Ex,
    input  logic             Jump_Ex,
    input  logic [31:0]      Target_Ex,
    output logic             IMem_Req,
    output logic [31:0]      IMem_Addr,
    input  logic             IMem_Ready,
    input  logic [31:0]      IMem_RData,
    output logic [31:0]      Instruction_ID,
    output logic [31:0]      PCPlus4_ID,
    output logic             Valid_ID,
    output logic [4:0]       Rs_ID,
    output logic [4:0]       Rt_ID,
    output logic [5:0]       Instruction_31_26,
    output logic [5:0]       Instruction_5_0,
    output logic [CNT_W-1:0] Stall_Cycles
);

    localparam logic [1:0] S_BOOT  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [31:0] BOOT_PC = RESET_PC & ~32'h3;

    logic [1:0]  state;
    logic [1:0]  state_n;
    logic [31:0] pc;
    logic [31:0] pc_n;
    logic [31:0] redirect_pc;
    logic [31:0] redirect_pc_n;
    logic [31:0] pc_plus4;
    logic [31:0] target;
    logic        redirect;
    logic        fetch_ok;
    logic        load;
    logic        bubble;

    assign redirect  = Branch_Ex | Jump_Ex;
    assign target    = Target_Ex & ~32'h3;
    assign pc_plus4  = pc + 32'd4;
    assign IMem_Req  = (state != S_BOOT);
    assign IMem_Addr = pc;
    assign fetch_ok  = IMem_Req & IMem_Ready;

    assign Rs_ID             = Instruction_ID[25:21];
    assign Rt_ID             = Instruction_ID[20:16];
    assign Instruction_31_26 = Instruction_ID[31:26];
    assign Instruction_5_0   = Instruction_ID[5:0];

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        redirect_pc_n = redirect_pc;
        load          = 1'b0;
        bubble        = 1'b0;
        case (state)
            S_BOOT: begin
                state_n = S_RUN;
                if (redirect) pc_n = target;
            end
            S_RUN: begin
                if (redirect && fetch_ok) begin
                    pc_n   = target;
                    bubble = 1'b1;
                end else if (redirect) begin
                    // address must stay stable until the outstanding fetch returns
                    redirect_pc_n = target;
                    bubble        = 1'b1;
                    state_n       = S_DRAIN;
                end else if (!PCWrite || !IF_ID_Write) begin
                    pc_n = pc;
                end else if (!IMem_Ready) begin
                    bubble = 1'b1;
                end else begin
                    load = 1'b1;
                    pc_n = pc_plus4;
                end
            end
            S_DRAIN: begin
                bubble = 1'b1;
                if (redirect) redirect_pc_n = target;
                if (IMem_Ready) begin
                    pc_n    = redirect ? target : redirect_pc;
                    state_n = S_RUN;
                end
            end
            default: state_n = S_BOOT;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state       <= S_BOOT;
            pc          <= BOOT_PC;
            redirect_pc <= 32'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            redirect_pc <= redirect_pc_n;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Instruction_ID <= 32'd0;
            PCPlus4_ID     <= 32'd0;
            Valid_ID       <= 1'b0;
        end else if (load) begin
            Instruction_ID <= IMem_RData;
            PCPlus4_ID     <= pc_plus4;
            Valid_ID       <= 1'b1;
        end else if (bubble) begin
            Instruction_ID <= 32'd0;
            PCPlus4_ID     <= 32'd0;
            Valid_ID       <= 1'b0;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            Stall_Cycles <= '0;
        end else if (!load && (Stall_Cycles != '1)) begin
            Stall_Cycles <= Stall_Cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage: boot, stalls, redirects,
// drain, async reset and counter saturation (CNT_W=4 copy).
module tb_if_fetch_stage;

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        PCWrite;
    logic        IF_ID_Write;
    logic        Branch_Ex;
    logic        Jump_Ex;
    logic [31:0] Target_Ex;
    logic        IMem_Req;
    logic [31:0] IMem_Addr;
    logic        IMem_Ready;
    logic [31:0] IMem_RData;
    logic [31:0] Instruction_ID;
    logic [31:0] PCPlus4_ID;
    logic        Valid_ID;
    logic [4:0]  Rs_ID;
    logic [4:0]  Rt_ID;
    logic [5:0]  Op_ID;
    logic [5:0]  Fn_ID;
    logic [31:0] Stall_Cycles;

    logic        n_req;
    logic [31:0] n_addr;
    logic [31:0] n_instr;
    logic [31:0] n_pcp4;
    logic        n_valid;
    logic [4:0]  n_rs;
    logic [4:0]  n_rt;
    logic [5:0]  n_op;
    logic [5:0]  n_fn;
    logic [3:0]  n_stall;

    logic        ovr_en;
    logic [31:0] ovr_data;

    int errors = 0;
    int checks = 0;

    always #5 Clk = ~Clk;

    always_comb begin
        IMem_RData = ovr_en ? ovr_data : (IMem_Addr >> 2) + 32'h100;
    end

    if_fetch_stage dut (
        .Clk(Clk), .Rst_n(Rst_n), .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write), .Branch_Ex(Branch_Ex),
        .Jump_Ex(Jump_Ex), .Target_Ex(Target_Ex),
        .IMem_Req(IMem_Req), .IMem_Addr(IMem_Addr),
        .IMem_Ready(IMem_Ready), .IMem_RData(IMem_RData),
        .Instruction_ID(Instruction_ID), .PCPlus4_ID(PCPlus4_ID),
        .Valid_ID(Valid_ID), .Rs_ID(Rs_ID), .Rt_ID(Rt_ID),
        .Instruction_31_26(Op_ID), .Instruction_5_0(Fn_ID),
        .Stall_Cycles(Stall_Cycles)
    );

    if_fetch_stage #(.CNT_W(4)) dut_n (
        .Clk(Clk), .Rst_n(Rst_n), .PCWrite(PCWrite),
        .IF_ID_Write(IF_ID_Write), .Branch_Ex(Branch_Ex),
        .Jump_Ex(Jump_Ex), .Target_Ex(Target_Ex),
        .IMem_Req(n_req), .IMem_Addr(n_addr),
        .IMem_Ready(IMem_Ready), .IMem_RData(IMem_RData),
        .Instruction_ID(n_instr), .PCPlus4_ID(n_pcp4),
        .Valid_ID(n_valid), .Rs_ID(n_rs), .Rt_ID(n_rt),
        .Instruction_31_26(n_op), .Instruction_5_0(n_fn),
        .Stall_Cycles(n_stall)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    task automatic chk_id(input string tag, input logic [31:0] addr,
                          input logic [31:0] instr, input logic valid,
                          input logic [31:0] stall);
        chk({tag, "_addr"}, IMem_Addr, addr);
        chk({tag, "_instr"}, Instruction_ID, instr);
        chk({tag, "_valid"}, {31'd0, Valid_ID}, {31'd0, valid});
        chk({tag, "_stall"}, Stall_Cycles, stall);
    endtask

    initial begin
        Rst_n       = 1'b0;
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        Branch_Ex   = 1'b0;
        Jump_Ex     = 1'b0;
        Target_Ex   = 32'd0;
        IMem_Ready  = 1'b1;
        ovr_en      = 1'b0;
        ovr_data    = 32'd0;

        #12;
        chk("rst_req", {31'd0, IMem_Req}, 32'd0);
        chk("rst_pcp4", PCPlus4_ID, 32'd0);
        chk_id("rst", 32'h0, 32'h0, 1'b0, 32'd0);

        Rst_n = 1'b1;
        #1;
        chk("boot_req", {31'd0, IMem_Req}, 32'd0);
        tick();
        chk("run_req", {31'd0, IMem_Req}, 32'd1);
        chk_id("boot", 32'h0, 32'h0, 1'b0, 32'd1);
        tick();
        chk_id("f0", 32'h4, 32'h100, 1'b1, 32'd1);
        chk("f0_pcp4", PCPlus4_ID, 32'h4);
        tick();
        chk_id("f1", 32'h8, 32'h101, 1'b1, 32'd1);
        chk("f1_funct", {26'd0, Fn_ID}, 32'd1);

        PCWrite     = 1'b0;
        IF_ID_Write = 1'b0;
        tick();
        chk_id("haz1", 32'h8, 32'h101, 1'b1, 32'd2);
        tick();
        chk_id("haz2", 32'h8, 32'h101, 1'b1, 32'd3);
        PCWrite     = 1'b1;
        IF_ID_Write = 1'b1;
        tick();
        chk_id("haz_end", 32'hC, 32'h102, 1'b1, 32'd3);

        Branch_Ex = 1'b1;
        Target_Ex = 32'h40;
        tick();
        chk_id("br", 32'h40, 32'h0, 1'b0, 32'd4);
        chk("br_pcp4", PCPlus4_ID, 32'h0);
        Branch_Ex = 1'b0;
        tick();
        chk_id("br_tgt", 32'h44, 32'h110, 1'b1, 32'd4);
        chk("br_pcp4b", PCPlus4_ID, 32'h44);

        IMem_Ready = 1'b0;
        tick();
        chk_id("fs1", 32'h44, 32'h0, 1'b0, 32'd5);
        tick();
        chk_id("fs2", 32'h44, 32'h0, 1'b0, 32'd6);
        tick();
        chk_id("fs3", 32'h44, 32'h0, 1'b0, 32'd7);
        IMem_Ready = 1'b1;
        tick();
        chk_id("fs_end", 32'h48, 32'h111, 1'b1, 32'd7);

        Jump_Ex   = 1'b1;
        Target_Ex = 32'h42;
        tick();
        chk_id("align", 32'h40, 32'h0, 1'b0, 32'd8);
        Jump_Ex = 1'b0;
        tick();
        chk_id("align_f", 32'h44, 32'h110, 1'b1, 32'd8);
        ovr_en   = 1'b1;
        ovr_data = 32'h8D2A_0004;
        tick();
        ovr_en = 1'b0;
        chk("fld_instr", Instruction_ID, 32'h8D2A_0004);
        chk("fld_rs", {27'd0, Rs_ID}, 32'd9);
        chk("fld_rt", {27'd0, Rt_ID}, 32'd10);
        chk("fld_op", {26'd0, Op_ID}, 32'h23);
        chk("fld_fn", {26'd0, Fn_ID}, 32'h4);
        chk("fld_pcp4", PCPlus4_ID, 32'h48);

        IMem_Ready = 1'b0;
        Jump_Ex    = 1'b1;
        Target_Ex  = 32'h80;
        tick();
        chk_id("dr1", 32'h48, 32'h0, 1'b0, 32'd9);
        chk("dr1_req", {31'd0, IMem_Req}, 32'd1);
        Jump_Ex = 1'b0;
        tick();
        chk_id("dr2", 32'h48, 32'h0, 1'b0, 32'd10);
        IMem_Ready = 1'b1;
        tick();
        chk_id("dr_exit", 32'h80, 32'h0, 1'b0, 32'd11);
        tick();
        chk_id("dr_fetch", 32'h84, 32'h120, 1'b1, 32'd11);

        IMem_Ready = 1'b0;
        Jump_Ex    = 1'b1;
        Target_Ex  = 32'h100;
        tick();
        chk_id("dd1", 32'h84, 32'h0, 1'b0, 32'd12);
        Target_Ex = 32'hC0;
        tick();
        chk_id("dd2", 32'h84, 32'h0, 1'b0, 32'd13);
        Jump_Ex    = 1'b0;
        IMem_Ready = 1'b1;
        tick();
        chk_id("dd_exit", 32'hC0, 32'h0, 1'b0, 32'd14);
        tick();
        chk_id("dd_fetch", 32'hC4, 32'h130, 1'b1, 32'd14);
        chk("sat_n14", {28'd0, n_stall}, 32'd14);

        IMem_Ready = 1'b0;
        Jump_Ex    = 1'b1;
        Target_Ex  = 32'h100;
        tick();
        Jump_Ex = 1'b0;
        chk("sat_n15", {28'd0, n_stall}, 32'd15);
        tick();
        chk("sat_hold", {28'd0, n_stall}, 32'd15);
        chk("sat_wide", Stall_Cycles, 32'd16);

        #1;
        Rst_n = 1'b0;
        #1;
        chk("ar_req", {31'd0, IMem_Req}, 32'd0);
        chk("ar_n", {28'd0, n_stall}, 32'd0);
        chk_id("ar", 32'h0, 32'h0, 1'b0, 32'd0);
        Rst_n      = 1'b1;
        IMem_Ready = 1'b1;
        #1;
        chk("ar_boot_req", {31'd0, IMem_Req}, 32'd0);
        tick();
        chk_id("ar_boot", 32'h0, 32'h0, 1'b0, 32'd1);
        tick();
        chk_id("ar_f0", 32'h4, 32'h100, 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
